// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester grant arbiter: requester count,
// index width, FSM state encoding and a small index-to-one-hot helper.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // Two-state FSM encoding, held in a plain one-bit state register.
  typedef logic arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_BUSY = 1'b1;

  // Converts a binary requester index into the matching one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner selection. The request vector is rotated left by the
// priority pointer so the current highest-priority requester lands in bit 3,
// a fixed 3>2>1>0 encode picks a winner, and the pointer is subtracted back
// out to recover the real requester index. Pointer 0 is plain fixed priority.
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    win,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      rot_win;

  // Rotate, priority-encode from bit 3 downward, then undo the rotation.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    dbl     = '0;
    rot     = '0;
    rot_win = '0;
    dbl     = {req, req} << ptr;
    rot     = dbl[2*NUM_REQ-1:NUM_REQ];
    casez (rot)
      4'b1???: rot_win = 2'd3;
      4'b01??: rot_win = 2'd2;
      4'b001?: rot_win = 2'd1;
      default: rot_win = 2'd0;
    endcase
  end

  assign win     = rot_win - ptr;
  assign any_req = |req;

endmodule

// File: rtl/priority_grant_arbiter.sv
// Four-requester arbiter in front of a shared resource mux. A winner is chosen
// from idle, the grant is registered and held while the winner keeps
// requesting, and it is force-released after MAX_HOLD cycles with a one-cycle
// timeout pulse. Each grant is followed by one all-zero turnaround cycle.
// In round-robin mode the just-granted requester drops to lowest priority.
module priority_grant_arbiter
  import arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               timeout
);

  arb_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pick_ptr;
  logic [ID_W-1:0]  win;
  logic             any_req;

  // Fixed mode always searches from requester 3 down.
  assign pick_ptr = RR_EN ? ptr : '0;

  rr_priority_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win     (win),
    .any_req (any_req)
  );

  // Grant FSM with registered outputs; requests from other requesters are
  // ignored while busy and only looked at again from idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update here
    // sees the values from before this edge, independent of statement order.
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      ptr         <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == ST_IDLE) begin
        if (any_req) begin
          state       <= ST_BUSY;
          hold_cnt    <= CNT_W'(1);
          grant       <= id_to_onehot(win);
          grant_id    <= win;
          grant_valid <= 1'b1;
          // Winner becomes lowest priority: highest is then (win - 1) mod 4.
          if (RR_EN) begin
            ptr <= -win;
          end
        end
      end else begin
        if (req[grant_id] && (hold_cnt < CNT_W'(MAX_HOLD))) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end else begin
          // Release, either voluntary or forced at the hold limit.
          state       <= ST_IDLE;
          hold_cnt    <= '0;
          grant       <= '0;
          grant_id    <= '0;
          grant_valid <= 1'b0;
          timeout     <= req[grant_id];
        end
      end
    end
  end

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Directed bench for the grant arbiter. Three instances share one clock:
// fixed priority with hold limit 8, round-robin with hold limit 2, and fixed
// priority with hold limit 1. Expected values are hand-computed constants.
module tb_priority_grant_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: fixed priority, MAX_HOLD=8.
  logic               rst_a;
  logic [NUM_REQ-1:0] req_a, grant_a;
  logic [ID_W-1:0]    id_a;
  logic               valid_a, tmo_a;

  // Instance B: round-robin, MAX_HOLD=2.
  logic               rst_b;
  logic [NUM_REQ-1:0] req_b, grant_b;
  logic [ID_W-1:0]    id_b;
  logic               valid_b, tmo_b;

  // Instance C: fixed priority, MAX_HOLD=1.
  logic               rst_c;
  logic [NUM_REQ-1:0] req_c, grant_c;
  logic [ID_W-1:0]    id_c;
  logic               valid_c, tmo_c;

  priority_grant_arbiter #(.RR_EN(1'b0), .MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .grant(grant_a),
    .grant_id(id_a), .grant_valid(valid_a), .timeout(tmo_a)
  );

  priority_grant_arbiter #(.RR_EN(1'b1), .MAX_HOLD(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .grant(grant_b),
    .grant_id(id_b), .grant_valid(valid_b), .timeout(tmo_b)
  );

  priority_grant_arbiter #(.RR_EN(1'b0), .MAX_HOLD(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .grant(grant_c),
    .grant_id(id_c), .grant_valid(valid_c), .timeout(tmo_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic v, input logic t);
    check({tag, ".grant"}, 32'(grant_a), 32'(g));
    check({tag, ".id"},    32'(id_a),    32'(id));
    check({tag, ".valid"}, 32'(valid_a), 32'(v));
    check({tag, ".tmo"},   32'(tmo_a),   32'(t));
  endtask

  task automatic check_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic v, input logic t);
    check({tag, ".grant"}, 32'(grant_b), 32'(g));
    check({tag, ".id"},    32'(id_b),    32'(id));
    check({tag, ".valid"}, 32'(valid_b), 32'(v));
    check({tag, ".tmo"},   32'(tmo_b),   32'(t));
  endtask

  logic [1:0] rr_seq [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

  initial begin
    rst_a = 1'b1; req_a = 4'b1111;
    rst_b = 1'b1; req_b = 4'b0000;
    rst_c = 1'b1; req_c = 4'b0000;
    #1;
    tick(); tick();

    // Reset with all requests high: everything stays zero.
    check_a("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_a = 1'b0;
    tick();
    check_a("rst_release", 4'b1000, 2'd3, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick();
    check_a("rst_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // Fixed priority: 2 beats 1; after release requester 1 wins.
    req_a = 4'b0110;
    tick();
    check_a("fix_win2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req_a = 4'b0010;
    tick();
    check_a("fix_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_a("fix_win1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick(); tick();
    check_a("fix_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Hold limit 8: exactly 8 grant cycles, then timeout, then re-grant.
    req_a = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_a($sformatf("tmo_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_a("tmo_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_a("tmo_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick(); tick();

    // Ignored contender: a one-cycle pulse on req[3] while 1 is busy.
    req_a = 4'b0010;
    tick();
    check_a("ign_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b1010;
    tick();
    check_a("ign_pulse", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b0010;
    tick();
    check_a("ign_after", 4'b0010, 2'd1, 1'b1, 1'b0);
    req_a = 4'b0000;
    tick();
    check_a("ign_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_a("ign_no3", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round-robin with hold limit 2 and all requests constantly high.
    req_b = 4'b1111;
    tick();
    rst_b = 1'b0;
    check_b("rr_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_b($sformatf("rr%0d_c1", k), id_to_onehot(rr_seq[k]), rr_seq[k], 1'b1, 1'b0);
      tick();
      check_b($sformatf("rr%0d_c2", k), id_to_onehot(rr_seq[k]), rr_seq[k], 1'b1, 1'b0);
      tick();
      check_b($sformatf("rr%0d_turn", k), 4'b0000, 2'd0, 1'b0, 1'b1);
    end

    // Mid-grant reset: next grant would be 2; reset drops it and restores
    // the pointer, so the first grant afterwards goes to requester 3 again.
    tick();
    check_b("mrst_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    rst_b = 1'b1;
    tick();
    check_b("mrst_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_b = 1'b0;
    tick();
    check_b("mrst_first", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Hold limit 1: single-cycle grants with timeout after every one.
    rst_c = 1'b0;
    req_c = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("h1_%0d_grant", k), 32'(grant_c), 32'h1);
      check($sformatf("h1_%0d_tmo0", k),  32'(tmo_c),   32'h0);
      tick();
      check($sformatf("h1_%0d_turn", k),  32'(grant_c), 32'h0);
      check($sformatf("h1_%0d_tmo1", k),  32'(tmo_c),   32'h1);
    end
    check("h1_id",    32'(id_c),    32'h0);
    check("h1_valid", 32'(valid_c), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
